// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen
//   Turns two raw, asynchronous push buttons (set and clear) into clean
//   single-cycle command pulses for a downstream SR flip-flop. Each button
//   goes through a 2-flop synchroniser and a counter-based debouncer. A
//   debounced rising edge then becomes one `s` or `r` pulse. The outputs
//   never assert S and R together: same-cycle or overlapping presses give
//   a `conflict` pulse instead.
//
// Parameters
//   DB_CYCLES  consecutive edges a synchronised input must disagree with
//              its debounced level before that level flips (1..2**CNT_W)
//   CNT_W      debounce counter width
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   asynchronous active-low reset
//   set_btn   in   raw set button (asynchronous, may bounce)
//   clr_btn   in   raw clear button (asynchronous, may bounce)
//   s         out  registered one-cycle set pulse
//   r         out  registered one-cycle reset pulse
//   conflict  out  registered one-cycle pulse when a press is suppressed

module sr_cmd_gen #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic conflict
);

    localparam int CH_SET = 0;
    localparam int CH_CLR = 1;

    // Terminal count: the level flips on the edge where cnt already holds
    // DB_CYCLES-1, so the counter never has to reach DB_CYCLES and never wraps.
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES - 1);

    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            db_q, db_d;
    logic [1:0]            db_prev_q, db_prev_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            rise;
    logic                  s_q, s_d;
    logic                  r_q, r_d;
    logic                  conflict_q, conflict_d;

    assign btn_raw = {clr_btn, set_btn};

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_MAX) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        db_prev_d = db_q;
        rise      = db_q & ~db_prev_q;
    end

    // A rise is only turned into a command when the other channel was low on
    // the previous cycle. Otherwise the flip-flop would see S and R overlap.
    always_comb begin
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        if (rise[CH_SET] && rise[CH_CLR]) begin
            conflict_d = 1'b1;
        end else if (rise[CH_SET]) begin
            if (db_prev_q[CH_CLR]) conflict_d = 1'b1;
            else                   s_d        = 1'b1;
        end else if (rise[CH_CLR]) begin
            if (db_prev_q[CH_SET]) conflict_d = 1'b1;
            else                   r_d        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            db_prev_q  <= '0;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            db_prev_q  <= db_prev_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;

endmodule
